uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single UART transmit channel (development board → GenshinKitchen byte path) between the manual-control requester and the automatic script-execution requester. Each requester gets a one-entry holding buffer. A round-robin arbiter picks the next byte and presents it on the UART data-in bits until the UART's transmit-done pulse arrives. 0x00 is driven between bytes as the idle filler. It sits between the Manual/Automatic blocks and the UART module and replaces the static switch-based mux.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 4096: cycles to wait in SEND for tx_ready before dropping the byte.
- GAP_CYCLES, default 2: cycles 0x00 is driven after each byte, range 1..255.

Ports:
- clock, input, 1: UART clock, the same clock as the UART module.
- reset, input, 1: asynchronous, active-high.
- man_valid, input, 1: manual requester has a byte.
- man_bits, input, 8: manual byte.
- man_ready, output, 1: manual holding slot is empty. Transfer happens when man_valid && man_ready.
- aut_valid, input, 1: automatic requester has a byte.
- aut_bits, input, 8: automatic byte.
- aut_ready, output, 1: automatic holding slot is empty.
- tx_bits, output, 8: to the UART io_dataIn_bits.
- tx_ready, input, 1: from the UART io_dataIn_ready, a 1-cycle pulse per byte sent.
- busy, output, 1: the FSM is not in IDLE.
- last_grant, output, 1: 0 means manual was served last, 1 means automatic.
- timeout_err, output, 1: sticky flag set by a dropped byte.
- clear_err, input, 1: synchronous clear of timeout_err.

## Operation

Holding slots:
- There is one 8-bit register plus a full flag per requester.
- The ready output equals !full, driven from the registered flag.
- Writing a byte sets full at the next edge.
- A byte of 0x00 is consumed (handshake completes) but not stored; full stays 0.
- A slot clears only when its byte completes SEND, either sent or timed out.
- A slot that clears in cycle N shows ready=1 in cycle N+1. There is no same-cycle refill.

Arbitration is evaluated only in IDLE:
- Only one slot full: grant that slot.
- Both full: grant the slot not equal to last_grant (round robin).
- last_grant is updated at grant.

FSM states are IDLE, SEND and GAP:
- IDLE: tx_bits=0x00. If any slot is full, latch the granted byte into the tx register, clear the timeout counter, go to SEND.
- SEND: tx_bits = the latched byte, held stable. The timeout counter increments each cycle.
  - If tx_ready=1: clear the granted slot and go to GAP.
  - Else if the counter reaches TIMEOUT_CYCLES-1: clear the granted slot, set timeout_err, go to GAP.
  - tx_ready and timeout in the same cycle counts as success; timeout_err is not set.
- GAP: tx_bits=0x00. The gap counter runs from 0 to GAP_CYCLES-1, then goes to IDLE.
- tx_ready outside SEND is ignored: no state change, no slot change.

Error flag:
- clear_err=1 clears timeout_err.
- Clear and set in the same cycle resolves to set.

Reset:
- Asynchronous and effective mid-operation.
- The FSM goes to IDLE, both slots empty, tx_bits=0x00, and both counters go to 0.
- Any in-flight byte is lost.

Widths:
- The timeout counter is clog2(TIMEOUT_CYCLES) bits.
- The gap counter is 8 bits.
- Neither counter wraps; both are cleared on state entry.

## Timing

Reset values:
- man_ready=1, aut_ready=1
- tx_bits=0x00
- busy=0, last_grant=1, so manual wins the first tie
- timeout_err=0

All outputs are registered; nothing is combinational from any input.

Latency:
- Byte written in cycle N, slot full in N+1.
- IDLE sees the full slot in N+1, and SEND with tx_bits valid begins in N+2.
- tx_ready in cycle M: GAP and tx_bits=0x00 from M+1.
- IDLE from M+1+GAP_CYCLES.
- The next SEND at the earliest is M+2+GAP_CYCLES.

busy=1 exactly while the state is SEND or GAP.

## Test plan

1. Reset, then man_valid with 0x35 for 1 cycle. Required: tx_bits=0x35 two cycles later and busy=1. A tx_ready pulse 10 cycles later gives tx_bits=0x00 for 2 cycles, then IDLE and man_ready=1.
2. Both slots loaded in the same cycle, manual 0x11 and automatic 0x22, tx_ready answering each SEND. Required: 0x11 sent first, then 0x22, last_grant sequence 0 then 1. Reload both: 0x11 is sent first again, because last_grant=1 points to automatic, so manual is next.
3. Automatic slot full and tx_ready never asserted, with TIMEOUT_CYCLES=16. Required: SEND lasts exactly 16 cycles, then timeout_err=1, aut_ready=1 after GAP, and timeout_err stays 1 until a clear_err pulse.
4. tx_ready pulses in IDLE and in GAP. Required: no state change and no slot cleared. Then tx_ready on the same cycle the timeout hits. Required: timeout_err stays 0.
5. man_bits=0x00 with man_valid. Required: the handshake completes, the slot stays empty, and busy stays 0.
6. Assert reset during SEND of 0x7A. Required: tx_bits=0x00, both ready=1 and busy=0 immediately, without waiting for a clock edge. After release, the byte is not retransmitted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of the UART transmit byte path
// between the manual and automatic requesters, with 0x00 idle filler.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       man_valid,
  input  logic [7:0] man_bits,
  output logic       man_ready,
  input  logic       aut_valid,
  input  logic [7:0] aut_bits,
  output logic       aut_ready,
  output logic [7:0] tx_bits,
  input  logic       tx_ready,
  output logic       busy,
  output logic       last_grant,
  output logic       timeout_err,
  input  logic       clear_err
);

  localparam int TW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t        state;
  logic          man_full;
  logic          aut_full;
  logic [7:0]    man_data;
  logic [7:0]    aut_data;
  logic          grant_aut;
  logic [TW-1:0] to_cnt;
  logic [7:0]    gap_cnt;

  logic man_take;
  logic aut_take;
  logic pick_aut;
  logic timed_out;
  logic done;

  // 0x00 is the idle filler, so it is accepted but never queued
  assign man_take = man_valid && !man_full
                 && (man_bits != 8'h00);
  assign aut_take = aut_valid && !aut_full
                 && (aut_bits != 8'h00);

  assign pick_aut  = aut_full && (!man_full || !last_grant);
  assign timed_out = (to_cnt == TO_LAST);
  assign done      = (state == SEND) && (tx_ready || timed_out);

  assign man_ready = !man_full;
  assign aut_ready = !aut_full;
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      man_full    <= 1'b0;
      aut_full    <= 1'b0;
      man_data    <= 8'h00;
      aut_data    <= 8'h00;
      grant_aut   <= 1'b0;
      last_grant  <= 1'b1;
      tx_bits     <= 8'h00;
      to_cnt      <= '0;
      gap_cnt     <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      if (man_take) begin
        man_full <= 1'b1;
        man_data <= man_bits;
      end
      if (aut_take) begin
        aut_full <= 1'b1;
        aut_data <= aut_bits;
      end
      if (done) begin
        if (grant_aut) aut_full <= 1'b0;
        else           man_full <= 1'b0;
      end

      // a late tx_ready on the timeout cycle still counts as sent
      if (done && !tx_ready) timeout_err <= 1'b1;
      else if (clear_err)    timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (man_full || aut_full) begin
            state      <= SEND;
            grant_aut  <= pick_aut;
            last_grant <= pick_aut;
            tx_bits    <= pick_aut ? aut_data : man_data;
            to_cnt     <= '0;
          end
        end
        SEND: begin
          if (done) begin
            state   <= GAP;
            tx_bits <= 8'h00;
            gap_cnt <= 8'h00;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
